fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined core.
- Owns the program counter (PC) and drives the word address into the combinational instruction memory.
- Captures the returned instruction into the IF/ID pipeline register for the decode stage.
- Handles start-up, stalls, branch redirects and HALT detection.

Parameters:
- N, 24, instruction width in bits; must match the instruction memory.
- AW, 14, PC/address width (word address).
- OPW, 4, opcode field width; opcode = instruction[N-1:N-OPW].
- HALT_OPCODE, 4'hF, opcode that stops fetch.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; leaves IDLE and begins fetching at PC 0.
- stall  input  1  hazard unit holds PC and IF/ID contents.
- redirect  input  1  branch/jump taken; load the target and flush IF/ID.
- redirect_target  input  AW  new PC when redirect=1.
- imem_address  output  AW  address to instruction memory; equals the PC register.
- imem_instruction  input  N  combinational read data from instruction memory.
- id_instruction  output  N  IF/ID instruction register.
- id_pc  output  AW  PC of id_instruction.
- id_valid  output  1  IF/ID holds a real instruction (0 = bubble).
- running  output  1  FSM in RUN.
- halted  output  1  FSM in HALTED.

Behaviour:
- Reset, asynchronous, rst_n=0:
  - pc=0, id_instruction=NOP (all zeros), id_pc=0, id_valid=0, state=IDLE, running=0, halted=0.
  - Applies immediately, including mid-fetch or mid-stall.
- imem_address = pc at all times. Memory is combinational, so the instruction at pc is captured on the next rising edge. Address-to-id_* latency is 1 cycle.
- FSM states: IDLE, RUN, HALTED. running and halted are decoded directly from the state register.
- IDLE:
  - pc holds; IF/ID holds bubble (id_valid=0).
  - start=1 -> RUN on the next edge; the first fetch is pc=0.
  - stall and redirect are ignored.
- RUN, per edge, priority high to low:
  - 1. redirect=1:
    - pc <= redirect_target.
    - IF/ID <= bubble (id_instruction=NOP, id_valid=0, id_pc=0).
    - Wins over a simultaneous stall.
    - Wins over HALT detection of the current word (wrong path); state stays RUN.
  - 2. stall=1: pc, id_instruction, id_pc and id_valid all hold.
  - 3. Normal fetch:
    - id_instruction <= imem_instruction, id_pc <= pc, id_valid <= 1.
    - If opcode(imem_instruction)==HALT_OPCODE: pc holds, state <= HALTED. The HALT word itself is delivered with id_valid=1.
    - Otherwise pc <= pc+1, modulo 2^AW (0x3FFF wraps to 0x0000).
- HALTED:
  - pc holds; IF/ID <= bubble every non-stalled edge.
  - stall=1 holds IF/ID.
  - redirect=1 -> pc <= redirect_target, IF/ID <= bubble, state <= RUN. This recovers from a speculatively fetched HALT.
  - start is ignored; only reset returns the FSM to IDLE.
- start while in RUN is ignored.
- redirect_target is not range-checked; full AW bits are used.

Decomposition:
- Shared package cpu_pkg:
  - N, AW, OPW, HALT_OPCODE.
  - NOP constant (N'b0).
  - fetch_state_t enum {IDLE, RUN, HALTED}.
  - Function opcode_of(instr).
- One natural sub-module: if_id_register (N+AW+1 bits; enable=~stall, synchronous clear=flush, async reset), reused by later pipeline registers.
- PC logic and FSM stay in fetch_stage.

Test Plan:
- Reset then start:
  - Stimulus: rst_n low 3 cycles, memory[0..2]=0x100001,0x200002,0x300003; start pulse.
  - Response: imem_address 0,1,2 on successive cycles; id_instruction=0x100001,id_pc=0,id_valid=1 one cycle after address 0; id_valid=0 before start.
- Stall:
  - Stimulus: stall high 2 cycles while pc=5.
  - Response: pc stays 5; id_* unchanged for 2 cycles; fetch resumes with pc=6 on the edge after stall drops.
- Redirect with simultaneous stall:
  - Stimulus: at pc=7, redirect=1, target=0x0040, stall=1.
  - Response: next cycle pc=0x0040, id_valid=0, id_instruction=0; following cycle id_pc=0x0040, id_valid=1.
- HALT:
  - Stimulus: memory[3]=0xF00000.
  - Response: id_instruction=0xF00000 with id_valid=1; halted=1; pc stays 3; all later id_valid=0. Then redirect target=0x0010 -> running=1, pc=0x10.
- Wrap-around:
  - Stimulus: redirect to 0x3FFF; memory[0x3FFF] not HALT.
  - Response: next pc=0x0000; id_pc=0x3FFF.
- Asynchronous reset mid-stall:
  - Stimulus: assert rst_n low between clock edges during RUN with stall=1.
  - Response: pc=0, id_valid=0, running=0 immediately, before the next edge; after release, the FSM waits in IDLE for start.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared core constants, the fetch FSM state type and instruction field helpers.
package cpu_pkg;

  localparam int unsigned N   = 24;
  localparam int unsigned AW  = 14;
  localparam int unsigned OPW = 4;

  localparam logic [OPW-1:0] HALT_OPCODE = 4'hF;
  localparam logic [N-1:0]   NOP         = '0;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } fetch_state_t;

  function automatic logic [OPW-1:0] opcode_of(input logic [N-1:0] instr);
    return instr[N-1 -: OPW];
  endfunction

endpackage

// File: rtl/if_id_register.sv
// Generic pipeline register: hold when en=0, synchronous clear on flush, async clear on reset.
module if_id_register
  import cpu_pkg::*;
#(
  parameter int unsigned W = N + AW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         flush,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // flush beats en so a redirect squashes the slot even while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (flush) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, sequences IDLE/RUN/HALTED and feeds the IF/ID register.
module fetch_stage
  import cpu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stall,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_target,
  output logic [AW-1:0] imem_address,
  input  logic [N-1:0]  imem_instruction,
  output logic [N-1:0]  id_instruction,
  output logic [AW-1:0] id_pc,
  output logic          id_valid,
  output logic          running,
  output logic          halted
);

  localparam int unsigned IfIdW = N + AW + 1;

  fetch_state_t     state_q, state_d;
  logic [AW-1:0]    pc_q, pc_d;
  logic             ifid_en, ifid_flush;
  logic [IfIdW-1:0] ifid_d, ifid_q;
  logic             is_halt;

  assign is_halt = (opcode_of(imem_instruction) == HALT_OPCODE);
  assign ifid_d  = {imem_instruction, pc_q, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        ifid_en    = ~stall;
        ifid_flush = redirect;
        if (redirect) begin
          pc_d = redirect_target;
        end else if (!stall) begin
          // a HALT word is delivered, but the PC parks on it
          if (is_halt) state_d = HALTED;
          else         pc_d    = pc_q + 1'b1;
        end
      end
      HALTED: begin
        ifid_flush = redirect | ~stall;
        if (redirect) begin
          pc_d    = redirect_target;
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    running      = (state_q == RUN);
    halted       = (state_q == HALTED);
    imem_address = pc_q;
  end

  if_id_register #(
    .W(IfIdW)
  ) u_if_id (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (ifid_en),
    .flush(ifid_flush),
    .d    (ifid_d),
    .q    (ifid_q)
  );

  assign {id_instruction, id_pc, id_valid} = ifid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized run against a model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [13:0] redirect_target = '0;
  logic [13:0] imem_address;
  logic [23:0] imem_instruction;
  logic [23:0] id_instruction;
  logic [13:0] id_pc;
  logic        id_valid;
  logic        running;
  logic        halted;

  logic [23:0] mem [16384];
  assign imem_instruction = mem[imem_address];

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 = waiting for start, 1 = fetching, 2 = stopped on HALT
  int          m_mode;
  int          m_pc;
  logic [23:0] m_ins;
  int          m_idpc;
  logic        m_idv;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_address    (imem_address),
    .imem_instruction(imem_instruction),
    .id_instruction  (id_instruction),
    .id_pc           (id_pc),
    .id_valid        (id_valid),
    .running         (running),
    .halted          (halted)
  );

  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_ins = '0; m_idpc = 0; m_idv = 1'b0;
  endtask

  // Predict the next cycle from the current inputs, then advance one edge and commit.
  task automatic tick();
    int          n_mode = m_mode, n_pc = m_pc, n_idpc = m_idpc;
    logic [23:0] n_ins = m_ins;
    logic        n_idv = m_idv;
    logic [23:0] w = mem[m_pc];
    if (!rst_n) begin
      n_mode = 0; n_pc = 0; n_ins = '0; n_idpc = 0; n_idv = 1'b0;
    end else if (m_mode == 0) begin
      if (start) n_mode = 1;
    end else if (m_mode == 1) begin
      if (redirect) begin
        n_pc = int'(redirect_target); n_ins = '0; n_idpc = 0; n_idv = 1'b0;
      end else if (!stall) begin
        n_ins = w; n_idpc = m_pc; n_idv = 1'b1;
        if (w[23:20] == 4'hF) n_mode = 2;
        else                  n_pc = (m_pc + 1) % 16384;
      end
    end else begin
      if (redirect) begin
        n_pc = int'(redirect_target); n_ins = '0; n_idpc = 0; n_idv = 1'b0; n_mode = 1;
      end else if (!stall) begin
        n_ins = '0; n_idpc = 0; n_idv = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    m_mode = n_mode; m_pc = n_pc; m_ins = n_ins; m_idpc = n_idpc; m_idv = n_idv;
  endtask

  task automatic test_reset();
    for (int a = 0; a < 16384; a++) mem[a] = {4'($urandom_range(0, 14)), 20'($urandom)};
    mem[0] = 24'h100001; mem[1] = 24'h200002; mem[2] = 24'h300003;
    model_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (imem_address !== 14'h0) begin errors++; $display("FAIL reset_addr got %h exp %h", imem_address, 14'h0); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", id_valid); end
    checks++; if (id_instruction !== 24'h0) begin errors++; $display("FAIL reset_ins got %h exp 0", id_instruction); end
    checks++; if ({running, halted} !== 2'b00) begin errors++; $display("FAIL reset_state got %b exp 00", {running, halted}); end
    rst_n = 1'b1;
    stall = 1'b1; redirect = 1'b1; redirect_target = 14'h123;
    repeat (2) tick();
    stall = 1'b0; redirect = 1'b0;
    checks++; if ({running, id_valid, imem_address} !== {1'b0, 1'b0, 14'h0}) begin
      errors++; $display("FAIL idle_hold got run=%b v=%b a=%h exp 0 0 0", running, id_valid, imem_address);
    end
  endtask

  task automatic test_start();
    start = 1'b1; tick(); start = 1'b0;
    checks++; if ({running, id_valid, imem_address} !== {1'b1, 1'b0, 14'h0}) begin
      errors++; $display("FAIL start_first got run=%b v=%b a=%h exp 1 0 0", running, id_valid, imem_address);
    end
    tick();
    checks++; if ({imem_address, id_instruction, id_pc, id_valid} !== {14'h1, 24'h100001, 14'h0, 1'b1}) begin
      errors++; $display("FAIL start_word0 got a=%h i=%h p=%h v=%b exp 1 100001 0 1", imem_address, id_instruction, id_pc, id_valid);
    end
    tick();
    checks++; if ({imem_address, id_instruction, id_pc} !== {14'h2, 24'h200002, 14'h1}) begin
      errors++; $display("FAIL start_word1 got a=%h i=%h p=%h exp 2 200002 1", imem_address, id_instruction, id_pc);
    end
  endtask

  task automatic test_stall();
    logic [23:0] snap;
    repeat (3) tick();
    snap = mem[4];
    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if ({imem_address, id_instruction, id_pc, id_valid} !== {14'h5, snap, 14'h4, 1'b1}) begin
        errors++; $display("FAIL stall_hold got a=%h i=%h p=%h v=%b exp 5 %h 4 1", imem_address, id_instruction, id_pc, id_valid, snap);
      end
    end
    stall = 1'b0; tick();
    checks++; if ({imem_address, id_instruction, id_pc} !== {14'h6, mem[5], 14'h5}) begin
      errors++; $display("FAIL stall_resume got a=%h i=%h p=%h exp 6 %h 5", imem_address, id_instruction, id_pc, mem[5]);
    end
  endtask

  task automatic test_redirect_stall();
    tick();
    redirect = 1'b1; redirect_target = 14'h0040; stall = 1'b1;
    tick();
    redirect = 1'b0; stall = 1'b0;
    checks++; if ({imem_address, id_instruction, id_pc, id_valid} !== {14'h40, 24'h0, 14'h0, 1'b0}) begin
      errors++; $display("FAIL redir_flush got a=%h i=%h p=%h v=%b exp 40 0 0 0", imem_address, id_instruction, id_pc, id_valid);
    end
    tick();
    checks++; if ({id_pc, id_valid, id_instruction} !== {14'h40, 1'b1, mem[14'h40]}) begin
      errors++; $display("FAIL redir_fetch got p=%h v=%b i=%h exp 40 1 %h", id_pc, id_valid, id_instruction, mem[14'h40]);
    end
  endtask

  task automatic test_halt();
    mem[3] = 24'hF00000;
    redirect = 1'b1; redirect_target = 14'h3; tick(); redirect = 1'b0;
    tick();
    checks++; if ({id_instruction, id_valid, halted, running, imem_address} !== {24'hF00000, 1'b1, 1'b1, 1'b0, 14'h3}) begin
      errors++; $display("FAIL halt_word got i=%h v=%b h=%b r=%b a=%h exp F00000 1 1 0 3", id_instruction, id_valid, halted, running, imem_address);
    end
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if ({id_valid, halted, imem_address} !== {1'b0, 1'b1, 14'h3}) begin
        errors++; $display("FAIL halt_park got v=%b h=%b a=%h exp 0 1 3", id_valid, halted, imem_address);
      end
    end
    start = 1'b0;
    redirect = 1'b1; redirect_target = 14'h0010; tick(); redirect = 1'b0;
    checks++; if ({running, halted, imem_address, id_valid} !== {1'b1, 1'b0, 14'h10, 1'b0}) begin
      errors++; $display("FAIL halt_recover got r=%b h=%b a=%h v=%b exp 1 0 10 0", running, halted, imem_address, id_valid);
    end
  endtask

  task automatic test_wrap();
    mem[14'h3FFF] = 24'h123456;
    redirect = 1'b1; redirect_target = 14'h3FFF; tick(); redirect = 1'b0;
    tick();
    checks++; if ({imem_address, id_pc, id_instruction, id_valid} !== {14'h0, 14'h3FFF, 24'h123456, 1'b1}) begin
      errors++; $display("FAIL wrap got a=%h p=%h i=%h v=%b exp 0 3FFF 123456 1", imem_address, id_pc, id_instruction, id_valid);
    end
  endtask

  task automatic test_random();
    logic [54:0] got, exp;
    for (int k = 0; k < 24; k++) mem[$urandom_range(0, 127)] = {4'hF, 20'($urandom)};
    for (int k = 0; k < 400; k++) begin
      stall    = ($urandom_range(0, 3) == 0);
      redirect = ($urandom_range(0, 9) == 0);
      start    = ($urandom_range(0, 19) == 0);
      redirect_target = ($urandom_range(0, 7) == 0) ? 14'($urandom) : 14'($urandom_range(0, 127));
      tick();
      got = {imem_address, id_instruction, id_pc, id_valid, running, halted};
      exp = {14'(m_pc), m_ins, 14'(m_idpc), m_idv, (m_mode == 1), (m_mode == 2)};
      checks++; if (got !== exp) begin
        errors++; $display("FAIL random_cycle%0d got %h exp %h", k, got, exp);
      end
    end
    stall = 1'b0; redirect = 1'b0; start = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int a = 32; a < 35; a++) mem[a] = 24'h0ABCDE;
    redirect = 1'b1; redirect_target = 14'h20; tick(); redirect = 1'b0;
    tick();
    stall = 1'b1; tick();
    checks++; if ({running, id_valid, imem_address} !== {1'b1, 1'b1, 14'h21}) begin
      errors++; $display("FAIL pre_reset got r=%b v=%b a=%h exp 1 1 21", running, id_valid, imem_address);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++; if ({imem_address, id_valid, running, halted} !== {14'h0, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL async_reset got a=%h v=%b r=%b h=%b exp 0 0 0 0", imem_address, id_valid, running, halted);
    end
    model_reset();
    tick();
    rst_n = 1'b1; stall = 1'b0;
    repeat (2) tick();
    checks++; if ({running, id_valid} !== 2'b00) begin
      errors++; $display("FAIL post_reset_idle got r=%b v=%b exp 0 0", running, id_valid);
    end
    start = 1'b1; tick(); start = 1'b0;
    checks++; if ({running, imem_address} !== {1'b1, 14'h0}) begin
      errors++; $display("FAIL restart got r=%b a=%h exp 1 0", running, imem_address);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_stall();
    test_redirect_stall();
    test_halt();
    test_wrap();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
